// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - forward-select encoding, RV32I opcodes and operand-use decode for the hazard block
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return (opcode != LUI) && (opcode != AUIPC) && (opcode != JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    return (opcode == OP) || (opcode == OP_IMM) || (opcode == LOAD) ||
           (opcode == LUI) || (opcode == AUIPC) || (opcode == JAL) || (opcode == JALR);
  endfunction

endpackage

// File: rtl/mc_scoreboard.sv
// rtl/mc_scoreboard.sv - single-entry tracker for one outstanding multicycle result
// Watchdog and sticky timeout flag exist only under HAZARD_FWD_MC_TIMEOUT_EN.
module mc_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int MC_CNT_W = 6
`ifdef HAZARD_FWD_MC_TIMEOUT_EN
  ,
  parameter int MC_TIMEOUT = 40
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mc_issue_i,
  input  logic [REG_AW-1:0] issue_rd_i,
  input  logic              mc_done_i,
  output logic              mc_busy_o,
  output logic [REG_AW-1:0] mc_rd_o
`ifdef HAZARD_FWD_MC_TIMEOUT_EN
  ,
  output logic              mc_timeout_err_o
`endif
);
  import hazard_pkg::*;

  sb_state_e           state_q, state_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic                timeout;

`ifdef HAZARD_FWD_MC_TIMEOUT_EN
  localparam logic [MC_CNT_W-1:0] TIMEOUT_CNT = MC_CNT_W'(MC_TIMEOUT);

  logic err_q, err_d;

  assign timeout          = (state_q == SB_BUSY) && (cnt_q == TIMEOUT_CNT);
  assign err_d            = err_q | (timeout & ~mc_done_i);
  assign mc_timeout_err_o = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SB_IDLE;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // A fresh issue wins over a retiring one so back-to-back ops stay tracked.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (state_q == SB_BUSY) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + {{(MC_CNT_W-1){1'b0}}, 1'b1};
      end
      if (mc_done_i || timeout) begin
        state_d = SB_IDLE;
        rd_d    = '0;
      end
    end
    if (mc_issue_i && (issue_rd_i != '0)) begin
      state_d = SB_BUSY;
      rd_d    = issue_rd_i;
      cnt_d   = '0;
    end
  end

  assign mc_busy_o = (state_q == SB_BUSY);
  assign mc_rd_o   = rd_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX forwarding, load-use and multicycle-scoreboard stall control
// Optional multicycle watchdog: HAZARD_FWD_MC_TIMEOUT_EN.
module hazard_forward_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MC_CNT_W = 6
`ifdef HAZARD_FWD_MC_TIMEOUT_EN
  ,
  parameter int MC_TIMEOUT = 40
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       inst_data_ID,
  input  logic [31:0]       inst_data_EX,
  input  logic [31:0]       inst_data_MEM,
  input  logic [31:0]       inst_data_WB,
  input  logic              regwrite_EX,
  input  logic              regwrite_MEM,
  input  logic              regwrite_WB,
  input  logic              memread_EX,
  input  logic              mc_issue_EX,
  input  logic              mc_done,
  output logic [1:0]        forward1,
  output logic [1:0]        forward2,
  output logic              stall_IF,
  output logic              stall_ID,
  output logic              flush_EX,
  output logic              mc_busy,
  output logic [REG_AW-1:0] mc_rd
`ifdef HAZARD_FWD_MC_TIMEOUT_EN
  ,
  output logic              mc_timeout_err
`endif
);
  import hazard_pkg::*;

  logic [6:0]        opc_id;
  logic [6:0]        funct7_id;
  logic [REG_AW-1:0] rs1_id, rs2_id, rd_id;
  logic [REG_AW-1:0] rs1_ex, rs2_ex, rd_ex;
  logic [REG_AW-1:0] rd_mem, rd_wb;
  logic              use1_id, use2_id, wr_id;
  logic              mem_fwd_ok, wb_fwd_ok;
  logic              load_use, sb_hazard, stall;
  fwd_sel_e          fwd1, fwd2;

  assign opc_id    = inst_data_ID[6:0];
  assign funct7_id = inst_data_ID[31:25];
  assign rd_id     = inst_data_ID[7 +: REG_AW];
  assign rs1_id    = inst_data_ID[15 +: REG_AW];
  assign rs2_id    = inst_data_ID[20 +: REG_AW];
  assign rd_ex     = inst_data_EX[7 +: REG_AW];
  assign rs1_ex    = inst_data_EX[15 +: REG_AW];
  assign rs2_ex    = inst_data_EX[20 +: REG_AW];
  assign rd_mem    = inst_data_MEM[7 +: REG_AW];
  assign rd_wb     = inst_data_WB[7 +: REG_AW];

  assign use1_id = uses_rs1(opc_id);
  assign use2_id = uses_rs2(opc_id);
  assign wr_id   = writes_rd(opc_id);

  assign mem_fwd_ok = regwrite_MEM && (rd_mem != '0);
  assign wb_fwd_ok  = regwrite_WB && (rd_wb != '0);

  always_comb begin
    fwd1 = FWD_RF;
    fwd2 = FWD_RF;
    if (mem_fwd_ok && (rd_mem == rs1_ex)) begin
      fwd1 = FWD_MEM;
    end else if (wb_fwd_ok && (rd_wb == rs1_ex)) begin
      fwd1 = FWD_WB;
    end
    if (mem_fwd_ok && (rd_mem == rs2_ex)) begin
      fwd2 = FWD_MEM;
    end else if (wb_fwd_ok && (rd_wb == rs2_ex)) begin
      fwd2 = FWD_WB;
    end
  end

  assign forward1 = fwd1;
  assign forward2 = fwd2;

  assign load_use = memread_EX && regwrite_EX && (rd_ex != '0) &&
                    ((use1_id && (rs1_id == rd_ex)) || (use2_id && (rs2_id == rd_ex)));

  // mc_done releases the stall immediately; the result reaches ID via WB forwarding.
  assign sb_hazard = mc_busy && !mc_done &&
                     ((use1_id && (rs1_id == mc_rd)) ||
                      (use2_id && (rs2_id == mc_rd)) ||
                      (wr_id && (rd_id == mc_rd)) ||
                      ((opc_id == OP) && (funct7_id == FUNCT7_MULDIV)));

  assign stall    = reset_n && (load_use || sb_hazard);
  assign stall_IF = stall;
  assign stall_ID = stall;
  assign flush_EX = stall;

  mc_scoreboard #(
    .REG_AW   (REG_AW),
    .MC_CNT_W (MC_CNT_W)
`ifdef HAZARD_FWD_MC_TIMEOUT_EN
    ,
    .MC_TIMEOUT (MC_TIMEOUT)
`endif
  ) u_mc_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .mc_issue_i (mc_issue_EX),
    .issue_rd_i (rd_ex),
    .mc_done_i  (mc_done),
    .mc_busy_o  (mc_busy),
    .mc_rd_o    (mc_rd)
`ifdef HAZARD_FWD_MC_TIMEOUT_EN
    ,
    .mc_timeout_err_o (mc_timeout_err)
`endif
  );

  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_data_ID[14:12],
                              inst_data_EX[31:25], inst_data_EX[14:12], inst_data_EX[6:0],
                              inst_data_MEM[31:12], inst_data_MEM[6:0],
                              inst_data_WB[31:12], inst_data_WB[6:0]};

endmodule
